// File: rtl/hack_pkg.sv
// Shared constants for the Hack CPU: instruction field positions, phase encoding, widths.
package hack_pkg;

  localparam int PC_W   = 15;
  localparam int DATA_W = 16;

  localparam int A_FLAG  = 15;
  localparam int A_SEL   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JMP_LT  = 2;
  localparam int JMP_EQ  = 1;
  localparam int JMP_GT  = 0;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

endpackage

// File: rtl/hack_cpu_if.sv
// Memory-side bus of the Hack CPU: ROM fetch, RAM access and phase indication.
interface hack_cpu_if;
  import hack_pkg::*;

  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] inM;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   addressM;
  logic [DATA_W-1:0] outM;
  logic              writeM;
  logic              phase;

  modport master (
    input  instruction, inM,
    output pc, addressM, outM, writeM, phase
  );

  modport slave (
    output instruction, inM,
    input  pc, addressM, outM, writeM, phase
  );

endinterface

// File: rtl/hack_alu.sv
// Hack ALU: optional zero/negate of each operand, AND or ADD, optional output negate.
module hack_alu (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        zx_i,
  input  logic        nx_i,
  input  logic        zy_i,
  input  logic        ny_i,
  input  logic        f_i,
  input  logic        no_i,
  output logic [15:0] out_o,
  output logic        zr_o,
  output logic        ng_o
);

  logic [15:0] x0, x1, y0, y1, fr;

  always_comb begin
    x0 = zx_i ? 16'h0000 : x_i;
    x1 = nx_i ? ~x0 : x0;
    y0 = zy_i ? 16'h0000 : y_i;
    y1 = ny_i ? ~y0 : y0;
    fr = f_i ? (x1 + y1) : (x1 & y1);
    out_o = no_i ? ~fr : fr;
  end

  assign zr_o = (out_o == 16'h0000);
  assign ng_o = out_o[15];

endmodule

// File: rtl/hack_inc16.sv
// 16-bit incrementer, wraps modulo 2^16.
module hack_inc16 (
  input  logic [15:0] in_i,
  output logic [15:0] out_o
);

  assign out_o = in_i + 16'd1;

endmodule

// File: rtl/hack_pc.sv
// Program counter: synchronous reset, then load, then increment (modulo 2^PC_W).
module hack_pc
  import hack_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] d_i,
  output logic [PC_W-1:0] q_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     inc_out;
  logic            unused_inc_msb;

  // The shared 16-bit incrementer's carry past PC_W is dropped, giving the wrap.
  hack_inc16 u_inc (
    .in_i  ({{(16-PC_W){1'b0}}, pc_q}),
    .out_o (inc_out)
  );
  assign unused_inc_msb = inc_out[15];

  always_comb begin
    pc_d = pc_q;
    if (reset)       pc_d = '0;
    else if (load_i) pc_d = d_i;
    else if (inc_i)  pc_d = inc_out[PC_W-1:0];
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign q_o = pc_q;

endmodule

// File: rtl/hack_cpu.sv
// Two-phase Hack CPU core: FETCH presents addresses, EXEC decodes and commits A/D/PC/M.
module hack_cpu
  import hack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  hack_cpu_if.master bus
);

  phase_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;

  logic              exec, is_c, jump;
  logic [DATA_W-1:0] alu_y, alu_out;
  logic              alu_zr, alu_ng;
  logic [5:0]        comp;
  logic [PC_W-1:0]   pc_val;

  assign exec = (state_q == PH_EXEC);
  assign is_c = bus.instruction[A_FLAG];
  assign comp = bus.instruction[COMP_HI:COMP_LO];
  assign alu_y = bus.instruction[A_SEL] ? bus.inM : a_q;

  hack_alu u_alu (
    .x_i   (d_q),
    .y_i   (alu_y),
    .zx_i  (comp[5]),
    .nx_i  (comp[4]),
    .zy_i  (comp[3]),
    .ny_i  (comp[2]),
    .f_i   (comp[1]),
    .no_i  (comp[0]),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  always_comb begin
    jump = exec & is_c & ~reset &
           ((bus.instruction[JMP_LT] & alu_ng) |
            (bus.instruction[JMP_EQ] & alu_zr) |
            (bus.instruction[JMP_GT] & ~alu_ng & ~alu_zr));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    if (reset) begin
      state_d = PH_FETCH;
      a_d     = '0;
      d_d     = '0;
    end else begin
      case (state_q)
        PH_FETCH: state_d = PH_EXEC;
        PH_EXEC: begin
          state_d = PH_FETCH;
          if (!is_c) begin
            a_d = bus.instruction;
          end else begin
            if (bus.instruction[DEST_A]) a_d = alu_out;
            if (bus.instruction[DEST_D]) d_d = alu_out;
          end
        end
        default: state_d = PH_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    a_q     <= a_d;
    d_q     <= d_d;
  end

  // Jump target is the pre-edge A, so a same-instruction A write cannot redirect it.
  hack_pc u_pc (
    .clk    (clk),
    .reset  (reset),
    .load_i (jump),
    .inc_i  (exec & ~jump),
    .d_i    (a_q[PC_W-1:0]),
    .q_o    (pc_val)
  );

  assign bus.pc       = pc_val;
  assign bus.addressM = a_q[PC_W-1:0];
  assign bus.outM     = alu_out;
  assign bus.writeM   = exec & is_c & bus.instruction[DEST_M] & ~reset;
  assign bus.phase    = (state_q == PH_EXEC);

endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu: drives instruction/inM per phase and checks bus outputs.
module tb_hack_cpu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hack_cpu_if bus ();

  hack_cpu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Called at a FETCH negedge; returns EXEC-phase samples, ends at next FETCH negedge.
  task automatic exec_instr(input logic [15:0] instr, input logic [15:0] inm,
                            output logic wm, output logic [14:0] am,
                            output logic [15:0] om, output logic ph);
    bus.instruction = instr;
    bus.inM = inm;
    @(negedge clk);
    wm = bus.writeM;
    am = bus.addressM;
    om = bus.outM;
    ph = bus.phase;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.instruction = 16'hE7C8;
    bus.inM = 16'h0000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.writeM !== 1'b0) begin
      errors++; $display("FAIL reset_writeM_held got %b want 0", bus.writeM);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 15'd0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.pc); end
    checks++;
    if (bus.addressM !== 15'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.addressM); end
    checks++;
    if (bus.writeM !== 1'b0) begin errors++; $display("FAIL reset_writeM got %b want 0", bus.writeM); end
    checks++;
    if (bus.phase !== 1'b0) begin errors++; $display("FAIL reset_phase got %b want 0", bus.phase); end
  endtask

  task automatic test_write_path();
    logic wm, ph; logic [14:0] am; logic [15:0] om;
    exec_instr(16'h0005, 16'h0000, wm, am, om, ph);
    checks++;
    if (ph !== 1'b1 || wm !== 1'b0) begin
      errors++; $display("FAIL ainst_exec got ph=%b wm=%b want ph=1 wm=0", ph, wm);
    end
    checks++;
    if (bus.addressM !== 15'd5 || bus.pc !== 15'd1) begin
      errors++; $display("FAIL ainst_load got addr=%h pc=%h want 5 1", bus.addressM, bus.pc);
    end
    exec_instr(16'hEC10, 16'h0000, wm, am, om, ph);
    exec_instr(16'hE7C8, 16'h0000, wm, am, om, ph);
    checks++;
    if (wm !== 1'b1 || am !== 15'd5 || om !== 16'h0006) begin
      errors++; $display("FAIL write_m got wm=%b addr=%h out=%h want 1 5 0006", wm, am, om);
    end
    checks++;
    if (bus.pc !== 15'd3) begin errors++; $display("FAIL write_pc got %h want 3", bus.pc); end
    checks++;
    if (bus.phase !== 1'b0) begin errors++; $display("FAIL phase_fetch got %b want 0", bus.phase); end
  endtask

  task automatic test_mem_read();
    logic wm, ph; logic [14:0] am; logic [15:0] om;
    exec_instr(16'hFC10, 16'h1234, wm, am, om, ph);
    checks++;
    if (wm !== 1'b0 || om !== 16'h1234) begin
      errors++; $display("FAIL mem_read got wm=%b out=%h want 0 1234", wm, om);
    end
    exec_instr(16'hE300, 16'hFFFF, wm, am, om, ph);
    checks++;
    if (om !== 16'h1234) begin errors++; $display("FAIL mem_read_d got %h want 1234", om); end
    checks++;
    if (bus.pc !== 15'd5) begin errors++; $display("FAIL mem_read_pc got %h want 5", bus.pc); end
  endtask

  task automatic test_cond_jump();
    logic wm, ph; logic [14:0] am; logic [15:0] om;
    exec_instr(16'h000A, 16'h0000, wm, am, om, ph);
    exec_instr(16'hEA90, 16'h0000, wm, am, om, ph);
    exec_instr(16'hE302, 16'h0000, wm, am, om, ph);
    checks++;
    if (bus.pc !== 15'd10) begin errors++; $display("FAIL jeq_taken got pc=%h want 000a", bus.pc); end
    exec_instr(16'hEFD0, 16'h0000, wm, am, om, ph);
    exec_instr(16'hE302, 16'h0000, wm, am, om, ph);
    checks++;
    if (bus.pc !== 15'd12) begin errors++; $display("FAIL jeq_not_taken got pc=%h want 000c", bus.pc); end
  endtask

  task automatic test_old_a();
    logic wm, ph; logic [14:0] am; logic [15:0] om;
    exec_instr(16'h0007, 16'h0000, wm, am, om, ph);
    exec_instr(16'hFCAF, 16'h0003, wm, am, om, ph);
    checks++;
    if (wm !== 1'b1 || am !== 15'd7 || om !== 16'h0002) begin
      errors++; $display("FAIL old_a_exec got wm=%b addr=%h out=%h want 1 7 0002", wm, am, om);
    end
    checks++;
    if (bus.pc !== 15'd7 || bus.addressM !== 15'd2) begin
      errors++; $display("FAIL old_a_after got pc=%h addr=%h want 7 2", bus.pc, bus.addressM);
    end
  endtask

  task automatic test_pc_wrap();
    logic wm, ph; logic [14:0] am; logic [15:0] om;
    exec_instr(16'h7FFF, 16'h0000, wm, am, om, ph);
    exec_instr(16'hEA87, 16'h0000, wm, am, om, ph);
    checks++;
    if (bus.pc !== 15'h7FFF) begin errors++; $display("FAIL jmp_top got pc=%h want 7fff", bus.pc); end
    exec_instr(16'h0000, 16'h0000, wm, am, om, ph);
    checks++;
    if (bus.pc !== 15'h0000) begin errors++; $display("FAIL pc_wrap got pc=%h want 0000", bus.pc); end
  endtask

  task automatic test_reset_in_exec();
    logic wm, ph; logic [14:0] am; logic [15:0] om;
    exec_instr(16'h0009, 16'h0000, wm, am, om, ph);
    exec_instr(16'hEC10, 16'h0000, wm, am, om, ph);
    bus.instruction = 16'hE7C8;
    @(negedge clk);
    checks++;
    if (bus.writeM !== 1'b1) begin errors++; $display("FAIL pre_abort_writeM got %b want 1", bus.writeM); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.writeM !== 1'b0) begin errors++; $display("FAIL abort_writeM got %b want 0", bus.writeM); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 15'd0 || bus.addressM !== 15'd0 || bus.phase !== 1'b0) begin
      errors++; $display("FAIL abort_state got pc=%h addr=%h ph=%b want 0 0 0", bus.pc, bus.addressM, bus.phase);
    end
    exec_instr(16'hE300, 16'h0000, wm, am, om, ph);
    checks++;
    if (om !== 16'h0000) begin errors++; $display("FAIL abort_d got %h want 0000", om); end
  endtask

  initial begin
    test_reset();
    test_write_path();
    test_mem_read();
    test_cond_jump();
    test_old_a();
    test_pc_wrap();
    test_reset_in_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
